beep_arbiter: RTL and testbench

//   Output stage between the tune/sound-effect generators (game-over melody,

---
 rtl/beep_arbiter.sv | 173 +++++++++++++++++
 tb/tb_beep_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beep_arbiter.sv
// beep_arbiter
//   Output stage between the tune/sound-effect generators and the single
//   buzzer pin. Fixed priority (highest index wins) selects one requesting
//   source; a minimum play time limits pre-emption, and every handover waits
//   for the current source's low phase (bounded by a timeout) followed by a
//   silent gap, so the buzzer never clicks.
//
//   Optional feature macro: VOLUME_EN
//     When defined, a PWM_BITS-bit free-running counter gates the buzzer
//     during PLAY/DRAIN, giving a volume control via the volume port.
//     When undefined, the volume port is absent and the buzzer carries the
//     raw source waveform.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   src_req     per-source buzzer request (level)
//   src_beep    per-source square-wave output
//   mute        global mute, overrides everything
//   volume      amplitude code, 0 = silent (VOLUME_EN only)
//   buzzer      registered buzzer drive
//   active_src  index of the source owning the buzzer
//   busy        high whenever the arbiter is not idle
module beep_arbiter #(
    parameter int N_SRC      = 4,
    parameter int MIN_HOLD   = 1_250_000,
    parameter int GAP_CYCLES = 100_000,
    parameter int PWM_BITS   = 3,
    localparam int SW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_SRC-1:0]    src_req,
    input  logic [N_SRC-1:0]    src_beep,
    input  logic                mute,
`ifdef VOLUME_EN
    input  logic [PWM_BITS-1:0] volume,
`endif
    output logic                buzzer,
    output logic [SW-1:0]       active_src,
    output logic                busy
);

    localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    if (N_SRC < 1 || MIN_HOLD < 1 || GAP_CYCLES < 1 || PWM_BITS < 1) begin : g_bad_cfg
        $error("beep_arbiter: all parameters must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] drain_cnt;

    logic [SW-1:0] pick;
    logic          any_req;
    logic          cur_beep;
    logic          beep_out;
    logic          preempt;

    // Highest requesting index wins; later iterations overwrite earlier ones.
    always_comb begin
        pick = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (src_req[i]) pick = SW'(i);
        end
    end

    assign any_req  = |src_req;
    assign cur_beep = src_beep[active_src];
    assign preempt  = (pick > active_src) && (hold_cnt >= HOLD_LAST);

`ifdef VOLUME_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Only the drive is gated; drain low detection keeps using cur_beep.
    assign beep_out = cur_beep & (pwm_cnt < volume);
`else
    assign beep_out = cur_beep;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            buzzer     <= 1'b0;
            active_src <= '0;
            busy       <= 1'b0;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            drain_cnt  <= '0;
        end else if (mute) begin
            // active_src is left alone: it only changes on PLAY entry.
            state     <= S_IDLE;
            buzzer    <= 1'b0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    buzzer <= 1'b0;
                    if (any_req) begin
                        active_src <= pick;
                        hold_cnt   <= '0;
                        state      <= S_PLAY;
                        busy       <= 1'b1;
                    end
                end

                S_PLAY: begin
                    buzzer <= beep_out;
                    if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
                    if (!src_req[active_src] || preempt) begin
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // drain_cnt counts DRAIN cycles already spent with the
                    // source high; the last allowed one forces silence.
                    if (!cur_beep || drain_cnt == GAP_LAST) begin
                        buzzer  <= 1'b0;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        buzzer    <= beep_out;
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    buzzer <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        if (any_req) begin
                            active_src <= pick;
                            hold_cnt   <= '0;
                            state      <= S_PLAY;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    buzzer <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beep_arbiter.sv
// tb_beep_arbiter
//   Checks beep_arbiter (N_SRC=4, MIN_HOLD=8, GAP_CYCLES=4, PWM_BITS=3)
//   against a timestamp-based behavioural model on every cycle, plus
//   directed scenarios with hand-computed expectations.
//   Honours VOLUME_EN in the same way as the design.
module tb_beep_arbiter;

    localparam int N_SRC      = 4;
    localparam int MIN_HOLD   = 8;
    localparam int GAP_CYCLES = 4;
    localparam int PWM_BITS   = 3;
    localparam int PWM_LEVELS = 1 << PWM_BITS;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_GAP   = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_SRC-1:0]    src_req;
    logic [N_SRC-1:0]    src_beep;
    logic                mute;
`ifdef VOLUME_EN
    logic [PWM_BITS-1:0] volume;
`endif
    logic                buzzer;
    logic [1:0]          active_src;
    logic                busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    beep_arbiter #(
        .N_SRC(N_SRC),
        .MIN_HOLD(MIN_HOLD),
        .GAP_CYCLES(GAP_CYCLES),
        .PWM_BITS(PWM_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_req(src_req),
        .src_beep(src_beep),
        .mute(mute),
`ifdef VOLUME_EN
        .volume(volume),
`endif
        .buzzer(buzzer),
        .active_src(active_src),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int highest(input logic [N_SRC-1:0] r);
        int h = -1;
        for (int i = 0; i < N_SRC; i++) if (r[i]) h = i;
        return h;
    endfunction

    // Model: tracks the current phase and the cycle it was entered; all
    // timing rules are expressed as the age of the phase.
    int m_mode = M_IDLE;
    int m_act  = 0;
    int m_cyc  = 0;
    int m_t0   = 0;
    bit m_buz  = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        int age, pk, nmode, nact;
        bit g, nb;
        if (rst) begin
            m_mode <= M_IDLE;
            m_act  <= 0;
            m_cyc  <= 0;
            m_t0   <= 0;
            m_buz  <= 1'b0;
        end else begin
            age = m_cyc - m_t0;
            pk  = highest(src_req);
`ifdef VOLUME_EN
            g = src_beep[m_act] && ((m_cyc % PWM_LEVELS) < int'(volume));
`else
            g = src_beep[m_act];
`endif
            nmode = m_mode;
            nact  = m_act;
            nb    = 1'b0;
            if (mute) begin
                nmode = M_IDLE;
            end else begin
                case (m_mode)
                    M_IDLE: if (pk >= 0) begin nact = pk; nmode = M_PLAY; end
                    M_PLAY: begin
                        nb = g;
                        if (!src_req[m_act] || (pk > m_act && age >= MIN_HOLD - 1))
                            nmode = M_DRAIN;
                    end
                    M_DRAIN: begin
                        if (src_beep[m_act] && age < GAP_CYCLES - 1) nb = g;
                        else nmode = M_GAP;
                    end
                    default: begin
                        if (age == GAP_CYCLES - 1) begin
                            if (pk >= 0) begin nact = pk; nmode = M_PLAY; end
                            else nmode = M_IDLE;
                        end
                    end
                endcase
            end
            if (nmode != m_mode) m_t0 <= m_cyc + 1;
            m_mode <= nmode;
            m_act  <= nact;
            m_buz  <= nb;
            m_cyc  <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_buzzer", int'(buzzer), int'(m_buz));
            chk("model_busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
            chk("model_active_src", int'(active_src), m_act);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(busy), 0);
    endtask

    int hp[N_SRC];
    int bc[N_SRC];

    initial begin : stim
        int n, hi, idle_at;
        rst = 1'b1; src_req = '0; src_beep = '0; mute = 1'b0;
`ifdef VOLUME_EN
        volume = 3'd7;
`endif
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_buzzer", int'(buzzer), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_active_src", int'(active_src), 0);

        // Single source, beep toggling every 3 cycles
        src_req = 4'b0001;
        @(negedge clk);
        chk("single_busy", int'(busy), 1);
        chk("single_active_src", int'(active_src), 0);
        for (int k = 0; k < 12; k++) begin
            if (k % 3 == 0) src_beep[0] = ~src_beep[0];
            @(negedge clk);
`ifndef VOLUME_EN
            chk("single_buzzer_follow", int'(buzzer), int'(src_beep[0]));
`endif
        end
        src_req = '0; src_beep = '0;
        wait_idle("single_idle");

        // Pre-emption by src 3 arriving at hold_cnt=2
        src_req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        src_req = 4'b1001;
        n = 2;
        while (active_src != 2'd3 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 12) begin
                chk("preempt_hold_active", int'(active_src), 0);
                chk("preempt_gap_buzzer", int'(buzzer), 0);
            end
        end
        chk("preempt_latency", n, 13);
        chk("preempt_active_src", int'(active_src), 3);
        src_req = '0;
        wait_idle("preempt_idle");

        // Lower-priority request does not pre-empt
        src_req = 4'b1000;
        @(negedge clk);
        src_req = 4'b1010;
        repeat (20) @(negedge clk);
        chk("nopreempt_active", int'(active_src), 3);
        src_req = 4'b0010;
        n = 0;
        while (active_src != 2'd1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("nopreempt_handover", n, 6);
        src_req = '0;
        wait_idle("nopreempt_idle");

        // Drain timeout with src 1 held high
        src_req = 4'b0010; src_beep = 4'b0010;
        @(negedge clk);
        repeat (3) @(negedge clk);
        src_req = '0;
        hi = 0; idle_at = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (buzzer) hi++;
            if (!busy && idle_at == 0) idle_at = i;
        end
`ifndef VOLUME_EN
        chk("timeout_high_cycles", hi, 4);
`endif
        chk("timeout_idle_cycle", idle_at, 9);
        src_beep = '0;

        // Mute during PLAY
        src_req = 4'b0100; src_beep = 4'b0100;
        @(negedge clk);
        repeat (3) @(negedge clk);
        mute = 1'b1;
        @(negedge clk);
        chk("mute_busy", int'(busy), 0);
        chk("mute_buzzer", int'(buzzer), 0);
        repeat (2) @(negedge clk);
        chk("mute_held_busy", int'(busy), 0);
        mute = 1'b0;
        @(negedge clk);
        chk("unmute_busy", int'(busy), 1);
        chk("unmute_active", int'(active_src), 2);

        // Asynchronous reset mid-PLAY on src 2
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_buzzer", int'(buzzer), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_active_src", int'(active_src), 0);
        src_req = '0; src_beep = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", int'(busy), 0);

`ifdef VOLUME_EN
        // Volume duty over an 8-cycle window
        volume = 3'd3; src_req = 4'b0001; src_beep = 4'b0001;
        @(negedge clk);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (buzzer) hi++;
        end
        chk("volume3_duty", hi, 3);
        volume = 3'd0;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (buzzer) hi++;
        end
        chk("volume0_duty", hi, 0);
        src_req = '0; src_beep = '0; volume = 3'd7;
        wait_idle("volume_idle");
`endif

        // Randomised traffic against the model
        for (int i = 0; i < N_SRC; i++) begin
            hp[i] = $urandom_range(1, 10);
            bc[i] = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N_SRC; i++) begin
                if ($urandom_range(0, 15) == 0) src_req[i] = ~src_req[i];
                bc[i]++;
                if (bc[i] >= hp[i]) begin
                    src_beep[i] = ~src_beep[i];
                    bc[i] = 0;
                    if ($urandom_range(0, 7) == 0) hp[i] = $urandom_range(1, 10);
                end
            end
            if (!mute && $urandom_range(0, 199) == 0) mute = 1'b1;
            else if (mute && $urandom_range(0, 7) == 0) mute = 1'b0;
`ifdef VOLUME_EN
            if ($urandom_range(0, 63) == 0) volume = 3'($urandom_range(0, 7));
`endif
        end
        mute = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
